// File: rtl/servo_dec_pkg.sv
// Shared types, widths and default tick constants for the servo pulse decoder.
// Tick constants assume a 10 MHz clock; override them through the top-level parameters.
package servo_dec_pkg;

   localparam int unsigned POS_W   = 8;
   localparam int unsigned WIDTH_W = 10;

   localparam int unsigned STEP_CYC       = 39;
   localparam int unsigned MIN_TICKS      = 256;
   localparam int unsigned GUARD_LO_TICKS = 128;
   localparam int unsigned GUARD_HI_TICKS = 640;
   localparam int unsigned TIMEOUT_TICKS  = 6400;

   typedef enum logic [1:0] {
      StArm,
      StIdle,
      StMeasure
   } state_e;

   // Offset the width by the 1.0 ms origin and clamp into the position code range.
   function automatic logic [POS_W-1:0] map_pos(input logic [WIDTH_W-1:0] w,
                                                input logic [WIDTH_W-1:0] min_ticks);
      logic [WIDTH_W-1:0] diff;
      diff = w - min_ticks;
      if (w <= min_ticks) begin
         return '0;
      end
      if (diff > WIDTH_W'((1 << POS_W) - 1)) begin
         return '1;
      end
      return diff[POS_W-1:0];
   endfunction

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// Control and result signals of one servo pulse decoder axis.
// The decoder takes the slave view; the driver of ena/pwm_in takes the master view.
interface servo_pulse_decoder_if;
   import servo_dec_pkg::*;

   logic               ena;
   logic               pwm_in;
   logic [POS_W-1:0]   pos;
   logic               pos_valid;
   logic [WIDTH_W-1:0] width_ticks;
   logic               err;
   logic               lost;

   modport master (
      output ena,
      output pwm_in,
      input  pos,
      input  pos_valid,
      input  width_ticks,
      input  err,
      input  lost
   );

   modport slave (
      input  ena,
      input  pwm_in,
      output pos,
      output pos_valid,
      output width_ticks,
      output err,
      output lost
   );

endinterface

// File: rtl/servo_in_sync.sv
// Two-flop synchronizer for the raw servo input with rise/fall strobes.
// SERVO_DEC_FILTER_EN adds a 3-sample agreement filter (2 cycles extra latency on both edges).
module servo_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic pwm_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q;
   logic level;
   logic level_prev_q;

   // Reset to "line high" so a pulse in flight at reset release never looks like a fresh rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= pwm_i;
         s2_q <= s1_q;
      end
   end

`ifdef SERVO_DEC_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q, filt_d;

   always_comb begin
      filt_d = filt_q;
      if (s2_q == hist_q[0] && s2_q == hist_q[1]) begin
         filt_d = s2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], s2_q};
         filt_q <= filt_d;
      end
   end

   assign level = filt_d;
`else
   assign level = s2_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_prev_q <= 1'b1;
      end else begin
         level_prev_q <= level;
      end
   end

   assign level_o = level;
   assign rise_o  = level & ~level_prev_q;
   assign fall_o  = ~level & level_prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures the high time of an RC servo pulse train and maps it to an 8-bit position,
// with range-error strobe and signal-lost flag. Optional input filter: SERVO_DEC_FILTER_EN.
module servo_pulse_decoder
   import servo_dec_pkg::*;
#(
   parameter int unsigned StepCyc      = STEP_CYC,
   parameter int unsigned MinTicks     = MIN_TICKS,
   parameter int unsigned GuardLoTicks = GUARD_LO_TICKS,
   parameter int unsigned GuardHiTicks = GUARD_HI_TICKS,
   parameter int unsigned TimeoutTicks = TIMEOUT_TICKS
) (
   input  logic                 clk,
   input  logic                 rst,
   servo_pulse_decoder_if.slave bus_io
);

   localparam int unsigned PrescW = (StepCyc > 1) ? $clog2(StepCyc) : 1;
   localparam int unsigned ToW    = $clog2(TimeoutTicks + 1);

   localparam logic [PrescW-1:0]  PrescMax = PrescW'(StepCyc - 1);
   localparam logic [WIDTH_W-1:0] WidthSat = WIDTH_W'(GuardHiTicks + 1);
   localparam logic [WIDTH_W-1:0] GuardLo  = WIDTH_W'(GuardLoTicks);
   localparam logic [WIDTH_W-1:0] GuardHi  = WIDTH_W'(GuardHiTicks);
   localparam logic [WIDTH_W-1:0] MinW     = WIDTH_W'(MinTicks);
   localparam logic [ToW-1:0]     ToLast   = ToW'(TimeoutTicks - 1);
   localparam logic [ToW-1:0]     ToMax    = ToW'(TimeoutTicks);

   logic level, rise, fall;

   state_e             state_q, state_d;
   logic [PrescW-1:0]  presc_q, presc_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic [ToW-1:0]     to_cnt_q, to_cnt_d;
   logic [WIDTH_W-1:0] meas_q, meas_d;
   logic               eval_q, eval_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               pos_valid_q, pos_valid_d;
   logic [WIDTH_W-1:0] width_ticks_q, width_ticks_d;
   logic               err_q, err_d;
   logic               lost_q, lost_d;
   logic               tick;
   logic [WIDTH_W-1:0] width_now;

   servo_in_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .pwm_i   (bus_io.pwm_in),
      .level_o (level),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      width_d       = width_q;
      to_cnt_d      = to_cnt_q;
      meas_d        = meas_q;
      eval_d        = 1'b0;
      pos_d         = pos_q;
      pos_valid_d   = 1'b0;
      width_ticks_d = width_ticks_q;
      err_d         = 1'b0;
      lost_d        = lost_q;
      tick          = (presc_q == PrescMax);
      // Include a tick that completes in the falling-edge cycle itself.
      width_now     = width_q;
      if (state_q == StMeasure && tick && width_q != WidthSat) begin
         width_now = width_q + 1'b1;
      end

      if (!bus_io.ena) begin
         state_d  = StArm;
         presc_d  = '0;
         width_d  = '0;
         to_cnt_d = '0;
      end else begin
         presc_d = (rise || tick) ? '0 : presc_q + 1'b1;

         if (rise) begin
            to_cnt_d = '0;
         end else if (tick && to_cnt_q != ToMax) begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
         if (!rise && tick && to_cnt_q == ToLast) begin
            lost_d = 1'b1;
         end

         unique case (state_q)
            StArm: begin
               if (!level) begin
                  state_d = StIdle;
               end
            end
            StIdle: begin
               if (rise) begin
                  state_d = StMeasure;
                  width_d = '0;
               end
            end
            StMeasure: begin
               width_d = width_now;
               if (fall) begin
                  state_d = StIdle;
                  meas_d  = width_now;
                  eval_d  = 1'b1;
               end
            end
            default: state_d = StArm;
         endcase

         if (eval_q) begin
            width_ticks_d = meas_q;
            if (meas_q < GuardLo || meas_q > GuardHi) begin
               err_d = 1'b1;
            end else begin
               pos_d       = map_pos(meas_q, MinW);
               pos_valid_d = 1'b1;
               lost_d      = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StArm;
         presc_q       <= '0;
         width_q       <= '0;
         to_cnt_q      <= '0;
         meas_q        <= '0;
         eval_q        <= 1'b0;
         pos_q         <= '0;
         pos_valid_q   <= 1'b0;
         width_ticks_q <= '0;
         err_q         <= 1'b0;
         lost_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         width_q       <= width_d;
         to_cnt_q      <= to_cnt_d;
         meas_q        <= meas_d;
         eval_q        <= eval_d;
         pos_q         <= pos_d;
         pos_valid_q   <= pos_valid_d;
         width_ticks_q <= width_ticks_d;
         err_q         <= err_d;
         lost_q        <= lost_d;
      end
   end

   assign bus_io.pos         = pos_q;
   assign bus_io.pos_valid   = pos_valid_q;
   assign bus_io.width_ticks = width_ticks_q;
   assign bus_io.err         = err_q;
   assign bus_io.lost        = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder, run with shortened tick constants
// (4 cycles/tick, 1000-tick timeout) so the whole sequence stays short.
module tb_servo_pulse_decoder;

   localparam int unsigned StepCyc  = 4;
   localparam int unsigned ToTicks  = 1000;
`ifdef SERVO_DEC_FILTER_EN
   localparam int unsigned FiltLat  = 2;
`else
   localparam int unsigned FiltLat  = 0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   pv_cnt;
   int   err_cnt;
   int   both_cnt;

   servo_pulse_decoder_if dec_if ();

   servo_pulse_decoder #(
      .StepCyc      (StepCyc),
      .MinTicks     (256),
      .GuardLoTicks (128),
      .GuardHiTicks (640),
      .TimeoutTicks (ToTicks)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (dec_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      pv_cnt   = 0;
      err_cnt  = 0;
      both_cnt = 0;
      forever begin
         @(negedge clk);
         if (dec_if.pos_valid === 1'b1) pv_cnt = pv_cnt + 1;
         if (dec_if.err === 1'b1) err_cnt = err_cnt + 1;
         if (dec_if.pos_valid === 1'b1 && dec_if.err === 1'b1) both_cnt = both_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive pwm_in high for exactly n clock cycles, then low long enough for evaluation.
   task automatic pulse(input int n, output int dpv, output int derr);
      int pv0, er0;
      pv0 = pv_cnt;
      er0 = err_cnt;
      dec_if.pwm_in = 1'b1;
      repeat (n) @(negedge clk);
      dec_if.pwm_in = 1'b0;
      repeat (8) @(negedge clk);
      dpv  = pv_cnt - pv0;
      derr = err_cnt - er0;
   endtask

   int dpv, derr, pv0, er0;

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      dec_if.ena    = 1'b1;
      dec_if.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pos", dec_if.pos, 0);
      chk("reset_pos_valid", dec_if.pos_valid, 0);
      chk("reset_width", dec_if.width_ticks, 0);
      chk("reset_err", dec_if.err, 0);
      chk("reset_lost", dec_if.lost, 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1.5 ms equivalent: 384 ticks -> pos 128
      pulse(1536, dpv, derr);
      chk("t1_pv_count", dpv, 1);
      chk("t1_err_count", derr, 0);
      chk("t1_pos", dec_if.pos, 128);
      chk("t1_width", dec_if.width_ticks, 384);
      chk("t1_lost", dec_if.lost, 0);

      pulse(1024, dpv, derr);
      chk("t2_1ms_pv", dpv, 1);
      chk("t2_1ms_pos", dec_if.pos, 0);
      chk("t2_1ms_width", dec_if.width_ticks, 256);
      pulse(2048, dpv, derr);
      chk("t2_2ms_pv", dpv, 1);
      chk("t2_2ms_pos", dec_if.pos, 255);
      chk("t2_2ms_width", dec_if.width_ticks, 512);
      pulse(800, dpv, derr);
      chk("t2_08ms_pv", dpv, 1);
      chk("t2_08ms_err", derr, 0);
      chk("t2_08ms_pos", dec_if.pos, 0);
      chk("t2_08ms_width", dec_if.width_ticks, 200);
      pulse(512, dpv, derr);
      chk("t2_lo_edge_pv", dpv, 1);
      chk("t2_lo_edge_width", dec_if.width_ticks, 128);
      pulse(2560, dpv, derr);
      chk("t2_hi_edge_pv", dpv, 1);
      chk("t2_hi_edge_pos", dec_if.pos, 255);
      chk("t2_hi_edge_width", dec_if.width_ticks, 640);

      pulse(1536, dpv, derr);
      chk("t3_setup_pos", dec_if.pos, 128);
      pulse(508, dpv, derr);
      chk("t3_127_err", derr, 1);
      chk("t3_127_pv", dpv, 0);
      chk("t3_127_width", dec_if.width_ticks, 127);
      chk("t3_127_pos", dec_if.pos, 128);
      pulse(304, dpv, derr);
      chk("t3_short_err", derr, 1);
      chk("t3_short_pv", dpv, 0);
      chk("t3_short_width", dec_if.width_ticks, 76);
      pulse(3000, dpv, derr);
      chk("t3_long_err", derr, 1);
      chk("t3_long_pv", dpv, 0);
      chk("t3_long_width", dec_if.width_ticks, 641);
      chk("t3_long_pos", dec_if.pos, 128);
      chk("t3_long_lost", dec_if.lost, 0);
      pulse(2564, dpv, derr);
      chk("t3_641_err", derr, 1);
      chk("t3_641_width", dec_if.width_ticks, 641);

      // Timeout: lost rises ToTicks*StepCyc cycles after the synchronized rise
      pulse(2048, dpv, derr);
      chk("t4_valid_pos", dec_if.pos, 255);
      chk("t4_valid_lost", dec_if.lost, 0);
      repeat (2 + FiltLat + ToTicks * StepCyc - 2048 - 8) @(negedge clk);
      chk("t4_lost_before", dec_if.lost, 0);
      @(negedge clk);
      chk("t4_lost_after", dec_if.lost, 1);
      repeat (2000) @(negedge clk);
      chk("t4_lost_held", dec_if.lost, 1);
      chk("t4_pos_held", dec_if.pos, 255);
      pulse(1536, dpv, derr);
      chk("t4_recover_pv", dpv, 1);
      chk("t4_recover_pos", dec_if.pos, 128);
      chk("t4_recover_lost", dec_if.lost, 0);

      // Reset in the middle of a pulse, released while the input is still high
      pv0 = pv_cnt;
      er0 = err_cnt;
      dec_if.pwm_in = 1'b1;
      repeat (500) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_rst_pos", dec_if.pos, 0);
      chk("t5_rst_lost", dec_if.lost, 1);
      rst = 1'b0;
      repeat (1036) @(negedge clk);
      dec_if.pwm_in = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_partial_pv", pv_cnt - pv0, 0);
      chk("t5_partial_err", err_cnt - er0, 0);
      chk("t5_partial_width", dec_if.width_ticks, 0);
      pulse(1536, dpv, derr);
      chk("t5_next_pv", dpv, 1);
      chk("t5_next_pos", dec_if.pos, 128);
      chk("t5_next_lost", dec_if.lost, 0);

      // Single-cycle glitch
      pulse(1024, dpv, derr);
      chk("t6_setup_pos", dec_if.pos, 0);
      pulse(1, dpv, derr);
      chk("t6_glitch_pv", dpv, 0);
`ifdef SERVO_DEC_FILTER_EN
      chk("t6_glitch_err", derr, 0);
      chk("t6_glitch_width", dec_if.width_ticks, 256);
`else
      chk("t6_glitch_err", derr, 1);
      chk("t6_glitch_width", dec_if.width_ticks, 0);
`endif
      chk("t6_glitch_pos", dec_if.pos, 0);
      pulse(1536, dpv, derr);
      chk("t6_after_pos", dec_if.pos, 128);

      // Disabled decoder ignores pulses and holds its outputs
      dec_if.ena = 1'b0;
      repeat (4) @(negedge clk);
      pulse(2048, dpv, derr);
      chk("t7_dis_pv", dpv, 0);
      chk("t7_dis_err", derr, 0);
      chk("t7_dis_pos", dec_if.pos, 128);
      chk("t7_dis_lost", dec_if.lost, 0);
      dec_if.ena = 1'b1;
      repeat (4) @(negedge clk);
      pulse(1024, dpv, derr);
      chk("t7_en_pv", dpv, 1);
      chk("t7_en_pos", dec_if.pos, 0);

      chk("never_both_strobes", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
